// File: rtl/rv_store_unit.sv
// Store-side data-memory access unit: lane-aligns rs2 data, builds byte selects and
// runs a req/ack write on the data bus, splitting misaligned stores into two beats.
module rv_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_sel,
  output logic        o_bus_we,
  input  logic        i_bus_ack,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] hi_wdata_r, hi_wdata_s;
  logic [3:0]  hi_sel_r, hi_sel_s;
  logic        mis_r, mis_s;

  logic        ready_s, req_s, done_s, err_s;
  logic [31:0] addr_s, wdata_s;
  logic [3:0]  sel_s;

  logic        accept_s;
  logic [1:0]  off_s;
  logic [3:0]  size_mask_s;
  logic [63:0] shifted_s;
  logic [7:0]  mask8_s;
  logic        f3_ok_s;
  logic        misaligned_s;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      3'b000:  size_mask = 4'b0001;
      3'b001:  size_mask = 4'b0011;
      3'b010:  size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_expand(input logic [3:0] m);
    lane_expand = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Request decode: data is masked to its size so untouched lanes stay zero.
  always_comb begin
    accept_s     = i_valid & o_ready;
    off_s        = i_addr[1:0];
    size_mask_s  = size_mask(i_funct3);
    f3_ok_s      = (size_mask_s != 4'b0000);
    shifted_s    = {32'h0000_0000, i_data & lane_expand(size_mask_s)} << {off_s, 3'b000};
    mask8_s      = {4'b0000, size_mask_s} << off_s;
    misaligned_s = (mask8_s[7:4] != 4'b0000);
  end

  // Next-state and next registered bus outputs.
  always_comb begin
    state_s    = state_r;
    hi_wdata_s = hi_wdata_r;
    hi_sel_s   = hi_sel_r;
    mis_s      = mis_r;
    req_s      = o_bus_req;
    addr_s     = o_bus_addr;
    wdata_s    = o_bus_wdata;
    sel_s      = o_bus_sel;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        req_s   = 1'b0;
        addr_s  = 32'h0000_0000;
        wdata_s = 32'h0000_0000;
        sel_s   = 4'b0000;
        if (accept_s) begin
          if (!f3_ok_s || (misaligned_s && !SPLIT_MISALIGNED)) begin
            err_s = 1'b1;
          end else begin
            state_s    = BEAT0;
            req_s      = 1'b1;
            addr_s     = {i_addr[31:2], 2'b00};
            wdata_s    = shifted_s[31:0];
            sel_s      = mask8_s[3:0];
            hi_wdata_s = shifted_s[63:32];
            hi_sel_s   = mask8_s[7:4];
            mis_s      = misaligned_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BEAT0: begin
        if (i_bus_ack) begin
          if (mis_r) begin
            state_s = BEAT1;
            addr_s  = o_bus_addr + 32'd4;
            wdata_s = hi_wdata_r;
            sel_s   = hi_sel_r;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
            req_s   = 1'b0;
            addr_s  = 32'h0000_0000;
            wdata_s = 32'h0000_0000;
            sel_s   = 4'b0000;
          end
        end else begin
          state_s = BEAT0;
        end
      end
      BEAT1: begin
        if (i_bus_ack) begin
          state_s = IDLE;
          done_s  = 1'b1;
          req_s   = 1'b0;
          addr_s  = 32'h0000_0000;
          wdata_s = 32'h0000_0000;
          sel_s   = 4'b0000;
        end else begin
          state_s = BEAT1;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        addr_s  = 32'h0000_0000;
        wdata_s = 32'h0000_0000;
        sel_s   = 4'b0000;
      end
    endcase
    ready_s = (state_s == IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r     <= IDLE;
      hi_wdata_r  <= 32'h0000_0000;
      hi_sel_r    <= 4'b0000;
      mis_r       <= 1'b0;
      o_ready     <= 1'b1;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'h0000_0000;
      o_bus_wdata <= 32'h0000_0000;
      o_bus_sel   <= 4'b0000;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_r     <= state_s;
      hi_wdata_r  <= hi_wdata_s;
      hi_sel_r    <= hi_sel_s;
      mis_r       <= mis_s;
      o_ready     <= ready_s;
      o_bus_req   <= req_s;
      o_bus_we    <= req_s;
      o_bus_addr  <= addr_s;
      o_bus_wdata <= wdata_s;
      o_bus_sel   <= sel_s;
      o_done      <= done_s;
      o_err       <= err_s;
    end
  end

endmodule
